// File: rtl/half_sub_ca.sv
// Unsigned WIDTH-bit half subtractor (diff = in1 - in2, borrow = in1 < in2) with a
// borrow monitor (sticky flag + saturating counter). Define HALF_SUB_REG_OUT_EN to register diff/borrow.
module half_sub_ca #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             borrow_seen,
  output logic [CNT_W-1:0] borrow_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // One extra bit on the subtraction turns the top bit into the borrow-out.
  logic [WIDTH:0]   sub_c;
  logic [WIDTH-1:0] diff_c;
  logic             borrow_c;

  assign sub_c    = {1'b0, in1} - {1'b0, in2};
  assign diff_c   = sub_c[WIDTH-1:0];
  assign borrow_c = sub_c[WIDTH];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;

  always_comb begin
    cnt_d  = cnt_q;
    seen_d = seen_q | borrow_c;
    if (borrow_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
    end
  end

  assign borrow_cnt  = cnt_q;
  assign borrow_seen = seen_q;

`ifdef HALF_SUB_REG_OUT_EN
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      diff_q   <= diff_c;
      borrow_q <= borrow_c;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
`else
  assign diff   = diff_c;
  assign borrow = borrow_c;
`endif

endmodule

// File: tb/tb_half_sub_ca.sv
// Bench for half_sub_ca: a WIDTH=4/CNT_W=16 and a WIDTH=1/CNT_W=2 instance against an
// arithmetic reference model; honours HALF_SUB_REG_OUT_EN when it is defined.
module tb_half_sub_ca;

  logic clk;
  logic rst_n;

  logic [3:0]  a_in1, a_in2, a_diff;
  logic        a_borrow, a_seen;
  logic [15:0] a_cnt;

  logic        b_in1, b_in2, b_diff;
  logic        b_borrow, b_seen;
  logic [1:0]  b_cnt;

  int total = 0;
  int bad   = 0;

  half_sub_ca #(.WIDTH(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .diff(a_diff), .borrow(a_borrow),
    .in1(a_in1), .in2(a_in2), .borrow_seen(a_seen), .borrow_cnt(a_cnt)
  );

  half_sub_ca #(.WIDTH(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .diff(b_diff), .borrow(b_borrow),
    .in1(b_in1), .in2(b_in2), .borrow_seen(b_seen), .borrow_cnt(b_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // reference model: plain integer arithmetic
  int m_cnt_a, m_cnt_b;
  int m_seen_a, m_seen_b;
  int m_rd_a, m_rb_a, m_rd_b, m_rb_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt_a = 0; m_cnt_b = 0; m_seen_a = 0; m_seen_b = 0;
      m_rd_a = 0; m_rb_a = 0; m_rd_b = 0; m_rb_b = 0;
    end else begin
      if (int'(a_in1) < int'(a_in2)) begin
        m_seen_a = 1;
        if (m_cnt_a < 65535) m_cnt_a = m_cnt_a + 1;
      end
      if (int'(b_in1) < int'(b_in2)) begin
        m_seen_b = 1;
        if (m_cnt_b < 3) m_cnt_b = m_cnt_b + 1;
      end
      m_rd_a = (int'(a_in1) - int'(a_in2)) & 15;
      m_rb_a = (int'(a_in1) < int'(a_in2)) ? 1 : 0;
      m_rd_b = (int'(b_in1) - int'(b_in2)) & 1;
      m_rb_b = (int'(b_in1) < int'(b_in2)) ? 1 : 0;
    end
  end

  // scoreboard: compare every falling edge
  always @(negedge clk) begin
    int ed_a, eb_a, ed_b, eb_b;
`ifdef HALF_SUB_REG_OUT_EN
    ed_a = m_rd_a; eb_a = m_rb_a; ed_b = m_rd_b; eb_b = m_rb_b;
`else
    ed_a = (int'(a_in1) - int'(a_in2)) & 15;
    eb_a = (int'(a_in1) < int'(a_in2)) ? 1 : 0;
    ed_b = (int'(b_in1) - int'(b_in2)) & 1;
    eb_b = (int'(b_in1) < int'(b_in2)) ? 1 : 0;
`endif
    check("a_diff",   32'(a_diff),   32'(ed_a));
    check("a_borrow", 32'(a_borrow), 32'(eb_a));
    check("a_cnt",    32'(a_cnt),    32'(m_cnt_a));
    check("a_seen",   32'(a_seen),   32'(m_seen_a));
    check("b_diff",   32'(b_diff),   32'(ed_b));
    check("b_borrow", 32'(b_borrow), 32'(eb_b));
    check("b_cnt",    32'(b_cnt),    32'(m_cnt_b));
    check("b_seen",   32'(b_seen),   32'(m_seen_b));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    #1;
    check("rst_a_cnt",  32'(a_cnt),  32'd0);
    check("rst_a_seen", 32'(a_seen), 32'd0);
    check("rst_b_cnt",  32'(b_cnt),  32'd0);
    check("rst_b_seen", 32'(b_seen), 32'd0);
`ifdef HALF_SUB_REG_OUT_EN
    check("rst_a_diff", 32'(a_diff), 32'd0);
    check("rst_b_borrow", 32'(b_borrow), 32'd0);
`endif
    rst_n = 1'b1;
  endtask

  logic [1:0] sweep_exp [4];
  logic [1:0] sweep_in;

  initial begin
    sweep_exp = '{2'b00, 2'b11, 2'b10, 2'b00};
    rst_n = 1'b0;
    a_in1 = '0; a_in2 = '0; b_in1 = 1'b0; b_in2 = 1'b0;
    #3;
    check("init_a_cnt",  32'(a_cnt),  32'd0);
    check("init_a_seen", 32'(a_seen), 32'd0);
    check("init_b_cnt",  32'(b_cnt),  32'd0);
    check("init_b_seen", 32'(b_seen), 32'd0);

    // WIDTH=1 truth table, checked in the same timestep-window as the change
    for (int i = 0; i < 4; i++) begin
      sweep_in = 2'(i);
      b_in1 = sweep_in[1];
      b_in2 = sweep_in[0];
      #1;
`ifdef HALF_SUB_REG_OUT_EN
      check("sweep_reg_diff",   32'(b_diff),   32'd0);
      check("sweep_reg_borrow", 32'(b_borrow), 32'd0);
`else
      check("sweep_diff",   32'(b_diff),   32'(sweep_exp[i][1]));
      check("sweep_borrow", 32'(b_borrow), 32'(sweep_exp[i][0]));
`endif
    end

`ifndef HALF_SUB_REG_OUT_EN
    a_in1 = 4'd3; a_in2 = 4'd5; #1;
    check("w4_3m5_diff",   32'(a_diff),   32'd14);
    check("w4_3m5_borrow", 32'(a_borrow), 32'd1);
    a_in1 = 4'd9; a_in2 = 4'd4; #1;
    check("w4_9m4_diff",   32'(a_diff),   32'd5);
    check("w4_9m4_borrow", 32'(a_borrow), 32'd0);
`endif

    // release reset while borrowing on both instances
    @(negedge clk);
    a_in1 = 4'd0; a_in2 = 4'd1; b_in1 = 1'b0; b_in2 = 1'b1;
    #1 rst_n = 1'b1;
    #1;
`ifdef HALF_SUB_REG_OUT_EN
    check("reg_pre_diff",   32'(b_diff),   32'd0);
    check("reg_pre_borrow", 32'(b_borrow), 32'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      step();
`ifdef HALF_SUB_REG_OUT_EN
      if (i == 0) begin
        check("reg_post_diff",   32'(b_diff),   32'd1);
        check("reg_post_borrow", 32'(b_borrow), 32'd1);
      end
`endif
    end
    check("hold5_a_cnt",  32'(a_cnt),  32'd5);
    check("hold5_a_seen", 32'(a_seen), 32'd1);
    check("sat_b_cnt",    32'(b_cnt),  32'd3);
    check("sat_b_seen",   32'(b_seen), 32'd1);

    a_in2 = 4'd0;
    for (int i = 0; i < 3; i++) step();
    check("noborrow_a_cnt",  32'(a_cnt),  32'd5);
    check("noborrow_a_seen", 32'(a_seen), 32'd1);
    check("sat8_b_cnt",      32'(b_cnt),  32'd3);

    reset_pulse();

    for (int i = 0; i < 400; i++) begin
      step();
      a_in1 = 4'($urandom_range(0, 15));
      a_in2 = 4'($urandom_range(0, 15));
      b_in1 = 1'($urandom_range(0, 1));
      b_in2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) reset_pulse();
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
